// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped tagged BTB with saturating counters, mispredict detection and stats
module branch_target_buffer #(
  parameter int XLEN     = 32,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int STAT_W   = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [XLEN-1:0]     pcF_i,
  input  logic [XLEN-1:0]     pcE_i,
  input  logic                we_i,
  input  logic                branch_taken_i,
  input  logic [XLEN-1:0]     dirsaltoE_i,
  input  logic [XLEN-1:0]     pcplus4E_i,
  input  logic                selbpE_i,
  input  logic [XLEN-1:0]     predtargetE_i,
  input  logic                desactivar_bp_i,
  output logic [XLEN-1:0]     dirobjetivoF_o,
  output logic [CTR_BITS-1:0] prediccionF_o,
  output logic                hitF_o,
  output logic                sel_mux_pred_o,
  output logic                flush_predictor_o,
  output logic [XLEN-1:0]     pc_correccion_o,
  output logic [STAT_W-1:0]   branch_count_o,
  output logic [STAT_W-1:0]   mispredict_count_o
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [CTR_BITS-1:0] CTR_WNT = ~CTR_WT;
  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  logic                valid_q [ENTRIES];
  logic [TAG_W-1:0]    tag_q   [ENTRIES];
  logic [XLEN-1:0]     tgt_q   [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q   [ENTRIES];
  logic [STAT_W-1:0]   branch_cnt_q, branch_cnt_d, misp_cnt_q, misp_cnt_d;
  logic [IDX_W-1:0]    idx_f, idx_e;
  logic [TAG_W-1:0]    tag_f, tag_e;
  logic                hit_e, wr_d;
  logic [CTR_BITS-1:0] ctr_e, ctr_d;
  logic [XLEN-1:0]     tgt_d;
  logic                unused_pc_lsbs;
  assign unused_pc_lsbs = ^{pcF_i[1:0], pcE_i[1:0]};
  assign idx_f = pcF_i[IDX_W+1:2];
  assign tag_f = pcF_i[XLEN-1:IDX_W+2];
  assign idx_e = pcE_i[IDX_W+1:2];
  assign tag_e = pcE_i[XLEN-1:IDX_W+2];
  assign hitF_o         = valid_q[idx_f] && (tag_q[idx_f] == tag_f);
  assign prediccionF_o  = ctr_q[idx_f];
  assign dirobjetivoF_o = tgt_q[idx_f];
  assign sel_mux_pred_o = hitF_o & ctr_q[idx_f][CTR_BITS-1] & ~desactivar_bp_i;
  assign flush_predictor_o = we_i & ((selbpE_i ^ branch_taken_i) |
                             (selbpE_i & branch_taken_i & (predtargetE_i != dirsaltoE_i))) & ~desactivar_bp_i;
  assign pc_correccion_o    = branch_taken_i ? dirsaltoE_i : pcplus4E_i;
  assign branch_count_o     = branch_cnt_q;
  assign mispredict_count_o = misp_cnt_q;
  // Next contents of the Execute-indexed entry: train on hit, allocate weakly-taken on a taken miss
  always_comb begin
    hit_e = valid_q[idx_e] && (tag_q[idx_e] == tag_e);
    ctr_e = ctr_q[idx_e];
    ctr_d = !hit_e ? CTR_WT
          : branch_taken_i ? ((ctr_e == CTR_MAX) ? ctr_e : ctr_e + CTR_BITS'(1))
          : ((ctr_e == '0) ? ctr_e : ctr_e - CTR_BITS'(1));
    tgt_d = branch_taken_i ? dirsaltoE_i : tgt_q[idx_e];
    wr_d  = we_i & (hit_e | branch_taken_i);
    branch_cnt_d = (we_i && branch_cnt_q != '1) ? branch_cnt_q + STAT_W'(1) : branch_cnt_q;
    misp_cnt_d   = (flush_predictor_o && misp_cnt_q != '1) ? misp_cnt_q + STAT_W'(1) : misp_cnt_q;
  end
  // Table and statistics registers; reset wins over a same-cycle update
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_WNT;
      end
      branch_cnt_q <= '0;
      misp_cnt_q   <= '0;
    end else begin
      if (wr_d) begin
        valid_q[idx_e] <= 1'b1;
        tag_q[idx_e]   <= tag_e;
        tgt_q[idx_e]   <= tgt_d;
        ctr_q[idx_e]   <= ctr_d;
      end
      branch_cnt_q <= branch_cnt_d;
      misp_cnt_q   <= misp_cnt_d;
    end
  end
endmodule

// File: doc/branch_target_buffer.md
Name: branch_target_buffer

Overview:
Parametrised branch target buffer for the 5-stage RISC-V pipeline: next generation of the single-entry last-time predictor. It holds a direct-mapped table of ENTRIES tagged entries, each with a target address and a CTR_BITS saturating counter.
- Fetch stage: predicts taken/target for the fetch PC.
- Execute stage: trains on resolved branches/jumps, detects direction and target mispredictions, supplies the corrected PC, and keeps performance counters.

Parameters:
XLEN, 32, address/data width
ENTRIES, 16, table entries; power of two, >= 2; IDX_W = log2(ENTRIES)
CTR_BITS, 2, saturating-counter width (>= 1)
STAT_W, 16, width of performance counters

Ports:
clk_i  input  1  clock, rising edge
reset_i  input  1  synchronous, active-high reset
pcF_i  input  XLEN  fetch PC for lookup
pcE_i  input  XLEN  PC of control instruction in Execute
we_i  input  1  Execute holds a resolved branch/jump this cycle
branch_taken_i  input  1  resolved direction
dirsaltoE_i  input  XLEN  resolved target
pcplus4E_i  input  XLEN  fall-through PC of Execute instruction
selbpE_i  input  1  fetch-time "predicted taken" carried down the pipe
predtargetE_i  input  XLEN  fetch-time predicted target carried down the pipe
desactivar_bp_i  input  1  disables prediction and flushing
dirobjetivoF_o  output  XLEN  predicted target for pcF_i
prediccionF_o  output  CTR_BITS  counter value of indexed entry
hitF_o  output  1  valid entry with tag match
sel_mux_pred_o  output  1  redirect fetch to dirobjetivoF_o
flush_predictor_o  output  1  misprediction; flush IF/ID and ID/EX
pc_correccion_o  output  XLEN  PC to fetch on misprediction
branch_count_o  output  STAT_W  resolved control instructions
mispredict_count_o  output  STAT_W  mispredictions

Behaviour:
- Addressing: index = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; pc[1:0] ignored.
- Lookup (combinational, zero latency):
  - hitF_o = valid[idx] & (tag[idx] == tagF).
  - prediccionF_o = ctr[idx] and dirobjetivoF_o = target[idx] regardless of hit.
  - sel_mux_pred_o = hitF_o & ctr[idx][MSB] & ~desactivar_bp_i.
- Mispredict detection (combinational):
  - dir_err = selbpE_i ^ branch_taken_i.
  - tgt_err = selbpE_i & branch_taken_i & (predtargetE_i != dirsaltoE_i).
  - flush_predictor_o = we_i & (dir_err | tgt_err) & ~desactivar_bp_i.
  - pc_correccion_o = branch_taken_i ? dirsaltoE_i : pcplus4E_i (always driven).
- Update (rising edge, we_i=1, using pcE_i index/tag). Training continues while desactivar_bp_i=1.
  - Hit: ctr saturating +1 if taken, -1 if not taken; target <= dirsaltoE_i if taken.
  - Miss and taken: allocate, overwriting the entry. valid=1, tag, target=dirsaltoE_i, ctr = weakly taken (1 followed by zeros, e.g. 2'b10).
  - Miss and not taken: no table change.
- Same-cycle lookup and update of the same index: lookup returns pre-update contents; the new contents are visible the next cycle.
- Statistics:
  - branch_count_o +1 when we_i=1.
  - mispredict_count_o +1 when flush_predictor_o=1.
  - Both saturate at all-ones and never wrap.
- Reset (synchronous, highest priority, overrides a same-cycle update):
  - All valid=0, ctr = weakly not taken (0 followed by ones, e.g. 2'b01), targets and tags = 0, statistics = 0.
  - Outputs after reset: hitF_o=0, sel_mux_pred_o=0, prediccionF_o=weakly-not-taken, dirobjetivoF_o=0.
  - flush_predictor_o=0 unless the Execute-stage inputs request it.
- Internal state is table plus two counters only; no FSM beyond the per-entry counters.

Test Plan:
- Reset then pcF_i=0x40 -> hitF_o=0, sel_mux_pred_o=0, prediccionF_o=2'b01; both stat counters 0.
- Taken branch we_i=1, pcE_i=0x40, dirsaltoE_i=0x100, selbpE_i=0 -> flush_predictor_o=1 and pc_correccion_o=0x100 in that cycle. Next cycle pcF_i=0x40 -> hitF_o=1, ctr=2'b10, sel_mux_pred_o=1, dirobjetivoF_o=0x100. mispredict_count_o=1, branch_count_o=1.
- Same entry: taken twice more -> ctr 2'b11, stays 2'b11 (saturation). Then not taken with selbpE_i=1 -> flush=1, pc_correccion_o=pcplus4E_i=0x44, ctr 2'b10.
- Alias: pcE_i=0x80 (same index, different tag) taken to 0x200 -> entry replaced. pcF_i=0x40 misses; pcF_i=0x80 hits with target 0x200.
- Target error: selbpE_i=1, taken, predtargetE_i=0x100, dirsaltoE_i=0x120 -> flush=1, pc_correccion_o=0x120, stored target becomes 0x120.
- desactivar_bp_i=1 with a valid taken entry -> sel_mux_pred_o=0, flush=0, table still trains. Assert reset_i during a we_i cycle -> entry not written, all state cleared.
